// File: rtl/hwce_stream_start_resp.sv
// hwce_stream_start_resp: start-handshake responder that issues a strided word-address stream
module hwce_stream_start_resp #(
    parameter int ADDR_WIDTH   = 32,
    parameter int SIZE_WIDTH   = 16,
    parameter int STRIDE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_i,
    input  logic                    req_start_i,
    output logic                    ready_start_o,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [SIZE_WIDTH-1:0]   trans_size_i,
    input  logic [SIZE_WIDTH-1:0]   line_length_i,
    input  logic [STRIDE_WIDTH-1:0] line_stride_i,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic                    addr_valid_o,
    input  logic                    addr_ready_i,
    output logic                    busy_o,
    output logic                    done_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t                  state;
    logic [SIZE_WIDTH-1:0]   last, line_last, word_cnt, line_cnt;
    logic                    line_en;
    logic [STRIDE_WIDTH-1:0] stride;
    logic [ADDR_WIDTH-1:0]   line_base, next_base;
    assign next_base     = line_base + ADDR_WIDTH'(stride);
    assign ready_start_o = state == IDLE;
    assign addr_valid_o  = state == RUN;
    assign busy_o        = state != IDLE;
    assign done_o        = state == DONE;
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            state     <= IDLE;
            addr_o    <= '0;
            line_base <= '0;
            last      <= '0;
            line_last <= '0;
            line_en   <= 1'b0;
            stride    <= '0;
            word_cnt  <= '0;
            line_cnt  <= '0;
        end else begin
            case (state)
                IDLE: if (req_start_i) begin
                    // terminal counts are stored pre-decremented so the counters never need to reach size
                    last      <= trans_size_i - SIZE_WIDTH'(1);
                    line_last <= line_length_i - SIZE_WIDTH'(1);
                    line_en   <= line_length_i != '0;
                    stride    <= line_stride_i;
                    addr_o    <= base_addr_i;
                    line_base <= base_addr_i;
                    word_cnt  <= '0;
                    line_cnt  <= '0;
                    state     <= trans_size_i == '0 ? DONE : RUN;
                end
                RUN: if (addr_ready_i) begin
                    word_cnt <= word_cnt + SIZE_WIDTH'(1);
                    if (word_cnt == last) begin
                        state <= DONE;
                    end else if (line_en && line_cnt == line_last) begin
                        line_base <= next_base;
                        addr_o    <= next_base;
                        line_cnt  <= '0;
                    end else begin
                        addr_o   <= addr_o + ADDR_WIDTH'(4);
                        line_cnt <= line_cnt + SIZE_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hwce_stream_start_resp.sv
// tb_hwce_stream_start_resp: directed scoreboard bench for hwce_stream_start_resp
module tb_hwce_stream_start_resp;
    logic        clk = 1'b0;
    logic        rst_n, clear, req_start, ready_start, addr_valid, addr_ready, busy, done;
    logic [31:0] base_addr, addr;
    logic [15:0] trans_size, line_length, line_stride;
    logic [31:0] expq[$];
    int          passed = 0, total = 0;
    int          hs, done_at;

    hwce_stream_start_resp dut (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .req_start_i(req_start),
        .ready_start_o(ready_start), .base_addr_i(base_addr), .trans_size_i(trans_size),
        .line_length_i(line_length), .line_stride_i(line_stride), .addr_o(addr),
        .addr_valid_o(addr_valid), .addr_ready_i(addr_ready), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // drives cfg at cycle 0, leaves the bench 1ns into cycle 1
    task automatic start(input logic [31:0] b, input logic [15:0] s, input logic [15:0] l, input logic [15:0] st);
        base_addr = b; trans_size = s; line_length = l; line_stride = st; req_start = 1'b1;
        chk("ready_before_start", ready_start, 1);
        tick();
        req_start = 1'b0;
        base_addr = 32'hDEAD_0000; trans_size = 16'hFFFF; line_length = 16'h7; line_stride = 16'h4444;
        chk("ready_low_after_start", ready_start, 0);
        chk("busy_after_start", busy, 1);
    endtask

    // mode 0: ready always high; mode 1: ready pattern 1-0-0 repeating
    task automatic drain(input int mode, input int budget);
        logic [31:0] held;
        logic        pend;
        pend = 1'b0; hs = 0; done_at = -1;
        for (int c = 1; c <= budget; c++) begin
            addr_ready = (mode == 0) ? 1'b1 : ((c - 1) % 3 == 0);
            #1;
            if (pend) chk("addr_stable", addr, held);
            pend = 1'b0;
            if (addr_valid && addr_ready) begin
                if (expq.size() == 0) chk("unexpected_hs", {31'b0, addr_valid}, 0);
                else chk("addr", addr, expq.pop_front());
                hs++;
            end else if (addr_valid) begin
                held = addr; pend = 1'b1;
            end
            if (done) begin
                done_at = c;
                chk("valid_low_at_done", {31'b0, addr_valid}, 0);
                break;
            end
            tick();
        end
    endtask

    task automatic post(input int exp_done, input int exp_hs);
        chk("done_cycle", done_at, exp_done);
        chk("handshakes", hs, exp_hs);
        chk("queue_empty", expq.size(), 0);
        tick();
        chk("done_single_pulse", {31'b0, done}, 0);
        chk("ready_back", {31'b0, ready_start}, 1);
        chk("busy_cleared", {31'b0, busy}, 0);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; req_start = 1'b0; addr_ready = 1'b0;
        base_addr = '0; trans_size = '0; line_length = '0; line_stride = '0;
        tick(); tick();
        chk("rst_ready", ready_start, 1);
        chk("rst_valid", addr_valid, 0);
        chk("rst_addr", addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        tick();
        // two lines of three words, no backpressure
        expq = '{32'h1000, 32'h1004, 32'h1008, 32'h1100, 32'h1104, 32'h1108};
        start(32'h1000, 16'd6, 16'd3, 16'h100);
        drain(0, 40);
        post(7, 6);
        // same stream with backpressure: handshakes at 1,4,7,10,13,16
        expq = '{32'h1000, 32'h1004, 32'h1008, 32'h1100, 32'h1104, 32'h1108};
        start(32'h1000, 16'd6, 16'd3, 16'h100);
        drain(1, 60);
        post(17, 6);
        // zero size goes straight to done
        start(32'h2222_0000, 16'd0, 16'd0, 16'd0);
        chk("zero_no_valid", addr_valid, 0);
        drain(0, 10);
        post(1, 0);
        // address wrap
        expq = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        start(32'hFFFF_FFF8, 16'd4, 16'd0, 16'h10);
        drain(0, 20);
        post(5, 4);
        // start request during RUN is ignored, then clear aborts the transfer
        start(32'h2000, 16'd8, 16'd0, 16'd0);
        addr_ready = 1'b1; req_start = 1'b1; base_addr = 32'h9000;
        #1;
        chk("clr_hs1", addr, 32'h2000);
        tick();
        req_start = 1'b0;
        chk("clr_hs2_no_restart", addr, 32'h2004);
        chk("clr_still_busy", busy, 1);
        tick();
        clear = 1'b1; req_start = 1'b1; addr_ready = 1'b0;
        tick();
        clear = 1'b0; req_start = 1'b0;
        chk("clr_valid", addr_valid, 0);
        chk("clr_ready", ready_start, 1);
        chk("clr_addr", addr, 0);
        chk("clr_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            chk("clr_no_done", done, 0);
            tick();
        end
        expq = '{32'h3000, 32'h3004};
        start(32'h3000, 16'd2, 16'd0, 16'd0);
        drain(0, 20);
        post(3, 2);
        // back-to-back with req_start held: handshakes 1,2 then 5,6; done 3 and 7
        expq = '{32'h4000, 32'h4004, 32'h5000, 32'h5004};
        base_addr = 32'h4000; trans_size = 16'd2; line_length = 16'd0; line_stride = 16'd0;
        req_start = 1'b1; addr_ready = 1'b1;
        tick();
        base_addr = 32'h5000;
        begin
            int hs_cyc[$];
            int dn_cyc[$];
            for (int c = 1; c <= 9; c++) begin
                if (c == 5) req_start = 1'b0;
                if (addr_valid && addr_ready) begin
                    hs_cyc.push_back(c);
                    if (expq.size() == 0) chk("b2b_unexpected_hs", {31'b0, addr_valid}, 0);
                    else chk("b2b_addr", addr, expq.pop_front());
                end
                if (done) dn_cyc.push_back(c);
                if (c == 4) chk("b2b_ready_at_4", ready_start, 1);
                tick();
            end
            chk("b2b_hs_count", hs_cyc.size(), 4);
            if (hs_cyc.size() == 4) begin
                chk("b2b_hs_c0", hs_cyc[0], 1);
                chk("b2b_hs_c1", hs_cyc[1], 2);
                chk("b2b_hs_c2", hs_cyc[2], 5);
                chk("b2b_hs_c3", hs_cyc[3], 6);
            end
            chk("b2b_done_count", dn_cyc.size(), 2);
            if (dn_cyc.size() == 2) begin
                chk("b2b_done0", dn_cyc[0], 3);
                chk("b2b_done1", dn_cyc[1], 7);
            end
            chk("b2b_idle_end", ready_start, 1);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
